// File: rtl/apb_uart_tx_pkg.sv
// Purpose: shared constants and types for the UART0 APB transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: register offsets, STATUS bit positions, TX FSM state type.
package apb_uart_tx_pkg;

  // Interconnect select index that routes to this slave.
  localparam int APB_PSELX_UART0 = 4;

  // Register offsets, decoded from PADDR[0] only.
  localparam logic UART_REG_DATA   = 1'b0;
  localparam logic UART_REG_STATUS = 1'b1;

  // STATUS register bit positions.
  localparam int UART_STAT_EMPTY     = 0;
  localparam int UART_STAT_FULL      = 1;
  localparam int UART_STAT_BUSY      = 2;
  localparam int UART_STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous FIFO holding bytes waiting to be serialised.
// Latency: push visible in count/empty one cycle later; dout shows the head entry combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller watches full_o/empty_o.
// Ports: clk/reset (sync, active-high), push_i/din_i write side, pop_i/dout_o read side,
//        count_o occupancy, full_o/empty_o flags.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i  & ~empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/apb_uart_tx.sv
// Purpose: APB slave for the UART0 window; queues written bytes and sends them as 8N1 frames.
// Latency: byte accepted at edge E starts its start bit at E+1 when idle; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: DATA writes are held with S_PREADY=0 while the TX FIFO is full.
// Ports: clk/reset (sync, active-high); S_P* APB slave signals (PADDR[0] selects DATA/STATUS);
//        uart_tx registered serial output, idle high.
module apb_uart_tx
  import apb_uart_tx_pkg::*;
#(
  parameter int BUS_WIDTH    = 16,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  output logic                 uart_tx
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  logic                 access;
  logic                 data_wr;
  logic                 push;
  logic                 pop;
  logic [7:0]           fifo_dout;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BUS_WIDTH-1:0] status;
  logic                 unused_bits;

  tx_state_e  state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q,  bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,   tx_d;
  logic          baud_last;

  // Only PADDR[0] and PWDATA[7:0] carry meaning.
  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:1], S_PWDATA[BUS_WIDTH-1:8]};

  // APB handshake is purely combinational on the current bus inputs.
  assign access   = S_PSELx & S_PENABLE;
  assign data_wr  = access & S_PWRITE & (S_PADDR[0] == UART_REG_DATA);
  assign S_PREADY = access & ~reset & ~(data_wr & fifo_full);
  assign push     = data_wr & S_PREADY;

  always_comb begin
    status = '0;
    status[UART_STAT_EMPTY]                  = fifo_empty;
    status[UART_STAT_FULL]                   = fifo_full;
    status[UART_STAT_BUSY]                   = (state_q != TX_IDLE);
    status[UART_STAT_COUNT_LSB +: CW]        = fifo_count;
  end

  // Reads of DATA, and everything during reset, return zero.
  assign S_PRDATA = (access & ~reset & ~S_PWRITE & (S_PADDR[0] == UART_REG_STATUS))
                    ? status : '0;

  uart_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (S_PWDATA[7:0]),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  // tx_d is the line level for the state being entered, so uart_tx
  // changes on the same edge as the state register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            // Shift right so the next bit to send is always shift_q[0].
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      TX_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = TX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

endmodule

// File: tb/tb_apb_uart_tx.sv
module tb_apb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, uart_tx;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int frames_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  apb_uart_tx #(
    .BUS_WIDTH    (16),
    .FIFO_DEPTH   (8),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .uart_tx   (uart_tx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Called just after a posedge; returns just after the completing posedge.
  task automatic apb_write(input logic [15:0] a, input logic [15:0] d,
                           input bit exp_push, input logic [7:0] exp_b, output int waits);
    bit timeout;
    timeout = 0;
    waits   = 0;
    psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    while (!pready && !timeout) begin
      waits++;
      if (waits > 500) timeout = 1;
      @(negedge clk);
    end
    @(posedge clk);
    if (!timeout && exp_push) exp_q.push_back(exp_b);
    #1 psel = 0; penable = 0; pwrite = 0;
    if (timeout) begin
      tests++;
      fails++;
      $display("FAIL write_timeout: PREADY still 0 after %0d cycles, expected 1", waits);
    end
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [15:0] d, output logic r);
    psel = 1; penable = 0; pwrite = 0; paddr = a;
    @(posedge clk); #1 penable = 1;
    @(negedge clk);
    d = prdata;
    r = pready;
    @(posedge clk); #1 psel = 0; penable = 0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d frames outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: captures each frame from its first low sample and scores it.
  initial begin : monitor
    logic       smp [FRAME];
    logic [7:0] b;
    int         start_cyc, prev_start, bad_start, bad_stop, unstable;
    bit         gap_exp, aborted;
    gap_exp    = 0;
    prev_start = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        gap_exp = 0;
      end else if (uart_tx === 1'b0) begin
        start_cyc = cyc;
        aborted   = 0;
        smp[0]    = uart_tx;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1;
            break;
          end
          smp[i] = uart_tx;
        end
        if (aborted) begin
          gap_exp = 0;
        end else begin
          if (gap_exp) chk("frame_gap", start_cyc - prev_start, FRAME + 1);
          bad_start = 0;
          bad_stop  = 0;
          unstable  = 0;
          for (int j = 0; j < CPB; j++) begin
            if (smp[j] !== 1'b0) bad_start++;
            if (smp[9*CPB + j] !== 1'b1) bad_stop++;
          end
          for (int k = 0; k < 8; k++) begin
            b[k] = smp[CPB + CPB*k];
            for (int j = 1; j < CPB; j++)
              if (smp[CPB + CPB*k + j] !== b[k]) unstable++;
          end
          chk("start_bit_low", bad_start, 0);
          chk("stop_bit_high", bad_stop, 0);
          chk("data_bit_stable", unstable, 0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got byte 0x%0h, expected no frame", b);
          end else begin
            chk("frame_byte", b, exp_q.pop_front());
          end
          frames_seen++;
          gap_exp    = (exp_q.size() != 0);
          prev_start = start_cyc;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [15:0] rd;
    logic        rdy;
    int          w, e1, lows, frames_before;
    logic [7:0]  burst [10];
    burst = '{8'h01, 8'h80, 8'h3C, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h12, 8'hE7, 8'h69};

    reset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge clk);
    #1 psel = 1; penable = 1; paddr = 16'h0001;
    @(negedge clk);
    chk("rst_pready", pready, 1'b0);
    chk("rst_prdata", prdata, 16'h0000);
    chk("rst_uart_tx", uart_tx, 1'b1);
    @(posedge clk); #1 psel = 0; penable = 0; reset = 0;

    apb_read(16'h0001, rd, rdy);
    chk("status_after_reset", rd, 16'h0001);
    chk("status_pready", rdy, 1'b1);
    chk("idle_uart_tx", uart_tx, 1'b1);

    // Single frame, first-transaction latency.
    apb_write(16'h0000, 16'h0055, 1, 8'h55, w);
    chk("w55_waits", w, 0);
    @(negedge clk); chk("tx_high_after_E", uart_tx, 1'b1);
    @(negedge clk); chk("tx_low_after_E1", uart_tx, 1'b0);
    @(posedge clk); #1;
    repeat (6) @(posedge clk);
    #1;
    apb_read(16'h0001, rd, rdy);
    chk("status_mid_frame", rd, 16'h0005);
    wait_drain();

    // Upper data bits ignored.
    apb_write(16'h0000, 16'hABCD, 1, 8'hCD, w);
    chk("wABCD_waits", w, 0);
    wait_drain();

    // Burst: 9 writes without wait states, status when full, 10th stalls.
    for (int i = 0; i < 9; i++) begin
      apb_write(16'h0000, {8'h5A, burst[i]}, 1, burst[i], w);
      chk("burst_no_wait", w, 0);
    end
    apb_read(16'h0001, rd, rdy);
    chk("status_full", rd, 16'h0806);
    apb_write(16'h0000, {8'h5A, burst[9]}, 1, burst[9], w);
    chk("write10_stalled", (w > 0), 1'b1);
    wait_drain();

    // Reset during data bit 3 with three bytes queued.
    apb_write(16'h0000, 16'h00A1, 1, 8'hA1, w);
    e1 = cyc;
    apb_write(16'h0000, 16'h00B2, 1, 8'hB2, w);
    apb_write(16'h0000, 16'h00C3, 1, 8'hC3, w);
    apb_write(16'h0000, 16'h00D4, 1, 8'hD4, w);
    while (cyc < e1 + 18) @(posedge clk);
    #1;
    exp_q.delete();
    frames_before = frames_seen;
    reset = 1;
    @(posedge clk);
    @(negedge clk); chk("tx_high_after_reset", uart_tx, 1'b1);
    @(posedge clk); #1 reset = 0;
    apb_read(16'h0001, rd, rdy);
    chk("status_after_midreset", rd, 16'h0001);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", lows, 0);
    chk("frame_count_after_reset", frames_seen, frames_before);
    @(posedge clk); #1;

    // Protocol corners.
    psel = 1; penable = 0; pwrite = 0; paddr = 16'h0001;
    @(negedge clk);
    chk("setup_pready", pready, 1'b0);
    chk("setup_prdata", prdata, 16'h0000);
    @(posedge clk); #1 psel = 0;
    apb_write(16'h0001, 16'h00EE, 0, 8'h00, w);
    chk("status_write_waits", w, 0);
    apb_read(16'h0001, rd, rdy);
    chk("status_after_status_write", rd, 16'h0001);
    apb_read(16'h0000, rd, rdy);
    chk("data_read_zero", rd, 16'h0000);
    chk("data_read_pready", rdy, 1'b1);

    repeat (5) @(posedge clk);
    chk("no_leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
